// File: rtl/fetch_pkg.sv
// Shared helpers and types for the fetch/unpack queue and its consumers.
// Derived-constant functions keep the width arithmetic in one place.
package fetch_pkg;

  function automatic int unsigned slots(input int unsigned bus_w, input int unsigned ins_w);
    return bus_w / ins_w;
  endfunction

  function automatic int unsigned ins_bytes(input int unsigned ins_w);
    return ins_w / 8;
  endfunction

  // Index of the instruction slot that pc selects within its bus beat.
  function automatic int unsigned slot_of_pc(input logic [63:0] pc, input int unsigned bus_w,
                                             input int unsigned ins_w);
    logic [63:0] off;
    off = pc & (64'(bus_w / 8) - 64'd1);
    return int'(off[31:0]) / (ins_w / 8);
  endfunction

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Circular instruction storage: up to SLOTS consecutive entries written per cycle
// starting at wr_ptr, one entry read from rd_ptr.
module fetch_queue_mem #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned INS_WIDTH = 32,
  parameter int unsigned SLOTS     = 2,
  parameter int unsigned PTR_W     = $clog2(DEPTH),
  parameter int unsigned N_W       = $clog2(SLOTS) + 1
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [PTR_W-1:0]             wr_ptr,
  input  logic [N_W-1:0]               wr_n,
  input  logic [SLOTS*INS_WIDTH-1:0]   wr_data,
  input  logic [PTR_W-1:0]             rd_ptr,
  output logic [INS_WIDTH-1:0]         rd_data
);

  logic [INS_WIDTH-1:0] mem_q [DEPTH];

  // Entry j of the packed write data lands at wr_ptr+j; the pointer sum wraps naturally.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < int'(SLOTS); j++) begin
        if (N_W'(j) < wr_n) begin
          mem_q[wr_ptr + PTR_W'(j)] <= wr_data[j*INS_WIDTH +: INS_WIDTH];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/fetch_unpack_queue.sv
// Fetch queue: unpacks bus beats into PC-tagged instructions for decode.
// Optional zero-instruction halt enabled by defining FETCH_HALT_ON_ZERO_EN.
module fetch_unpack_queue
  import fetch_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned INS_WIDTH      = 32,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  input  logic                       bus_valid,
  input  logic [BUS_DATA_WIDTH-1:0]  bus_data,
  output logic                       bus_ready,
  output logic                       ins_valid,
  output logic [INS_WIDTH-1:0]       ins,
  output logic [ADDR_WIDTH-1:0]      ins_pc,
  input  logic                       ins_ready,
  output logic [$clog2(DEPTH):0]     ins_count,
  output logic                       halt
);

  localparam int unsigned SLOTS     = slots(BUS_DATA_WIDTH, INS_WIDTH);
  localparam int unsigned INS_BYTES = ins_bytes(INS_WIDTH);
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned N_W       = $clog2(SLOTS) + 1;
  localparam int unsigned SKIP_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SKIP_W-1:0] RESET_SKIP =
    SKIP_W'(slot_of_pc(64'(RESET_PC), BUS_DATA_WIDTH, INS_WIDTH));

  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]     head_pc_q, head_pc_d;
  logic [SKIP_W-1:0]         skip_q, skip_d;
  logic                      halt_w, push, pop;
  logic [N_W-1:0]            push_n;
  logic [BUS_DATA_WIDTH-1:0] shifted_data;
  logic [INS_WIDTH-1:0]      rd_data;

  assign bus_ready = !reset && !redirect && !halt_w && (count_q <= CNT_W'(DEPTH - SLOTS));
  assign ins_valid = !reset && !halt_w && (count_q != '0);
  assign push      = bus_valid && bus_ready;
  assign pop       = ins_valid && ins_ready && !redirect;
  assign push_n    = N_W'(SLOTS) - N_W'(skip_q);
  // Skipped low slots are shifted out so the kept ones pack from entry 0.
  assign shifted_data = bus_data >> (skip_q * INS_WIDTH);

  always_comb begin
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    head_pc_d = head_pc_q;
    skip_d    = skip_q;
    if (redirect) begin
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      head_pc_d = redirect_pc & ~ADDR_WIDTH'(INS_BYTES - 1);
      skip_d    = SKIP_W'(slot_of_pc(64'(redirect_pc), BUS_DATA_WIDTH, INS_WIDTH));
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        skip_d   = '0;
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        head_pc_d = head_pc_q + ADDR_WIDTH'(INS_BYTES);
      end
      count_d = count_q + CNT_W'(push ? push_n : N_W'(0)) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      head_pc_q <= RESET_PC;
      skip_q    <= RESET_SKIP;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      head_pc_q <= head_pc_d;
      skip_q    <= skip_d;
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  logic halt_q, halt_d;

  always_comb begin
    halt_d = halt_q;
    if (redirect) begin
      halt_d = 1'b0;
    end else if (pop && (rd_data == '0)) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign halt_w = halt_q;
`else
  assign halt_w = 1'b0;
`endif

  fetch_queue_mem #(
    .DEPTH     (DEPTH),
    .INS_WIDTH (INS_WIDTH),
    .SLOTS     (SLOTS),
    .PTR_W     (PTR_W),
    .N_W       (N_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_n    (push_n),
    .wr_data (shifted_data[SLOTS*INS_WIDTH-1:0]),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign ins       = rd_data;
  assign ins_pc    = head_pc_q;
  assign ins_count = count_q;
  assign halt      = halt_w;

endmodule

// File: tb/tb_fetch_unpack_queue.sv
// Randomized bench for fetch_unpack_queue against a queue-of-entries reference model.
// Halt behaviour is modelled when FETCH_HALT_ON_ZERO_EN is defined.
module tb_fetch_unpack_queue;

  localparam int BW = 64;
  localparam int IW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 64;
  localparam int SLOTS = BW / IW;
  localparam int INS_BYTES = IW / 8;
  localparam int BUS_BYTES = BW / 8;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk;
  logic          reset, redirect, bus_valid, ins_ready;
  logic [AW-1:0] redirect_pc;
  logic [BW-1:0] bus_data;
  logic          bus_ready, ins_valid, halt;
  logic [IW-1:0] ins;
  logic [AW-1:0] ins_pc;
  logic [$clog2(DEPTH):0] ins_count;

  fetch_unpack_queue #(
    .BUS_DATA_WIDTH (BW),
    .INS_WIDTH      (IW),
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (AW),
    .RESET_PC       (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus_valid   (bus_valid),
    .bus_data    (bus_data),
    .bus_ready   (bus_ready),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_ready   (ins_ready),
    .ins_count   (ins_count),
    .halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] ins;
    logic [63:0]   pc;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  int          m_skip;
  bit          m_halt;
  bit          last_acc;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check against the model, advance the model, return just after the edge.
  task automatic cyc(input bit rst, input bit rd, input logic [63:0] rpc,
                     input bit bv, input logic [63:0] bd, input bit ir);
    bit   exp_ready, exp_valid;
    ent_t e;
    @(negedge clk);
    reset = rst; redirect = rd; redirect_pc = rpc;
    bus_valid = bv; bus_data = bd; ins_ready = ir;
    #1;
    exp_ready = !rst && !rd && !m_halt && (mq.size() <= DEPTH - SLOTS);
    exp_valid = !rst && !m_halt && (mq.size() != 0);
    check_eq("bus_ready", 64'(bus_ready), 64'(exp_ready));
    check_eq("ins_valid", 64'(ins_valid), 64'(exp_valid));
    check_eq("ins_count", 64'(ins_count), 64'(mq.size()));
    check_eq("halt", 64'(halt), 64'(m_halt));
    if (exp_valid) begin
      check_eq("ins", 64'(ins), 64'(mq[0].ins));
      check_eq("ins_pc", ins_pc, mq[0].pc);
    end
    last_acc = bv && exp_ready;
    $display("cyc t=%0t rst=%0d rd=%0d bv=%0d acc=%0d ir=%0d pop=%0d cnt=%0d",
             $time, rst, rd, bv, last_acc, ir, exp_valid && ir && !rd, mq.size());
    if (rst) begin
      mq.delete();
      m_pc = RESET_PC;
      m_skip = int'((RESET_PC % 64'(BUS_BYTES)) / 64'(INS_BYTES));
      m_halt = 1'b0;
    end else if (rd) begin
      mq.delete();
      m_pc = rpc - (rpc % 64'(INS_BYTES));
      m_skip = int'((rpc % 64'(BUS_BYTES)) / 64'(INS_BYTES));
      m_halt = 1'b0;
    end else begin
      if (exp_valid && ir) begin
        e = mq.pop_front();
        if (HALT_EN && e.ins == '0) m_halt = 1'b1;
      end
      if (last_acc) begin
        for (int k = m_skip; k < SLOTS; k++) begin
          e.ins = bd[k*IW +: IW];
          e.pc  = m_pc;
          mq.push_back(e);
          m_pc = m_pc + 64'(INS_BYTES);
        end
        m_skip = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] gen_beat();
    logic [63:0] b;
    for (int k = 0; k < SLOTS; k++) begin
      b[k*IW +: IW] = ($urandom_range(0, 9) == 0) ? '0 : IW'($urandom);
    end
    return b;
  endfunction

  initial begin
    bit          pv;
    logic [63:0] pd, rpc;
    int          r;
    bit          rst, rd, ir;

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    bus_valid = 1'b0; bus_data = '0; ins_ready = 1'b0;
    m_pc = RESET_PC; m_skip = 0; m_halt = 1'b0; last_acc = 1'b0;

    // Reset, then one beat drained with ins_ready held high.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("rst_count", 64'(ins_count), 64'd0);
    check_eq("rst_pc", ins_pc, RESET_PC);
    cyc(0, 0, 0, 1, 64'h2222_2222_1111_1111, 1);
    check_eq("beat1_ins", 64'(ins), 64'h1111_1111);
    check_eq("beat1_cnt", 64'(ins_count), 64'd2);
    cyc(0, 0, 0, 0, 0, 1);
    check_eq("beat1_ins2", 64'(ins), 64'h2222_2222);
    check_eq("beat1_pc2", ins_pc, 64'h4);
    cyc(0, 0, 0, 0, 0, 1);
    check_eq("beat1_empty", 64'(ins_valid), 64'd0);

    // Fill to full with decode stalled, then drain.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, {32'(i*2+1) | 32'hA000_0000, 32'(i*2) | 32'hA000_0000}, 0);
    check_eq("full_cnt", 64'(ins_count), 64'd8);
    check_eq("full_ready", 64'(bus_ready), 64'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1);

    // Count 6, then simultaneous push and pop; pointers wrap.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, gen_beat() | 64'h1, 0);
    cyc(0, 0, 0, 1, 64'h5555_5555_4444_4444, 1);
    check_eq("pushpop_cnt", 64'(ins_count), 64'd7);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 1);

    // Redirect into the middle of a beat; the beat offered with redirect is dropped.
    cyc(0, 1, 64'h1004, 1, 64'hDEAD_DEAD_DEAD_DEAD, 1);
    cyc(0, 0, 0, 1, 64'hBBBB_BBBB_AAAA_AAAA, 0);
    check_eq("redir_ins", 64'(ins), 64'hBBBB_BBBB);
    check_eq("redir_pc", ins_pc, 64'h1004);
    check_eq("redir_cnt", 64'(ins_count), 64'd1);

    // Build count 5 and reset mid-stream.
    cyc(0, 0, 0, 1, 64'h0000_0007_0000_0006, 0);
    cyc(0, 0, 0, 1, 64'h0000_0009_0000_0008, 0);
    check_eq("pre_rst_cnt", 64'(ins_count), 64'd5);
    cyc(1, 0, 0, 1, 64'h1, 1);
    check_eq("mid_rst_cnt", 64'(ins_count), 64'd0);
    check_eq("mid_rst_pc", ins_pc, RESET_PC);
    cyc(0, 0, 0, 0, 0, 0);

    if (HALT_EN) begin
      cyc(0, 0, 0, 1, 64'h0000_0000_0000_0013, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      check_eq("halt_set", 64'(halt), 64'd1);
      cyc(0, 1, 64'h40, 0, 0, 0);
      check_eq("halt_clr", 64'(halt), 64'd0);
    end

    // Randomized traffic with the producer holding each beat until accepted.
    pv = 1'b0; pd = '0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      rst = (r < 2);
      rd = !rst && (r < 7);
      rpc = {32'h0, 32'($urandom_range(0, 32'hFFFF))};
      if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      if (!pv && $urandom_range(0, 2) != 0) begin
        pv = 1'b1;
        pd = gen_beat();
      end
      ir = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(rst, rd, rpc, pv, pd, ir);
      if (last_acc) pv = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unpack_queue.md
Name: fetch_unpack_queue

Overview:
- Parametrised successor to the two-slot instruction fetcher.
- Accepts BUS_DATA_WIDTH-wide memory beats over a valid/ready handshake and splits each beat into SLOTS = BUS_DATA_WIDTH/INS_WIDTH instructions, low slot first.
- Buffers up to DEPTH instructions, tags each with its PC, and presents them one per cycle to decode over a valid/ready handshake.
- Supports redirect/flush with mid-beat start alignment. Sits between the Sysbus read path and decode.

Parameters:
- BUS_DATA_WIDTH, 64, memory beat width in bits; a power of 2, at least INS_WIDTH.
- INS_WIDTH, 32, instruction width in bits; a power of 2, at least 8.
- DEPTH, 8, queue capacity in instructions; a power of 2, multiple of SLOTS, at least 2*SLOTS.
- ADDR_WIDTH, 64, PC width.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  flush the queue and restart the PC.
- redirect_pc  in  ADDR_WIDTH  new PC, sampled when redirect=1.
- bus_valid  in  1  bus_data holds a beat.
- bus_data  in  BUS_DATA_WIDTH  fetched beat, little-endian slot order.
- bus_ready  out  1  queue can accept a whole beat.
- ins_valid  out  1  head instruction valid.
- ins  out  INS_WIDTH  head instruction.
- ins_pc  out  ADDR_WIDTH  PC of the head instruction.
- ins_ready  in  1  decode accepts the head.
- ins_count  out  $clog2(DEPTH)+1  current occupancy.
- halt  out  1  halt flag; see Optional Feature.

Behaviour:
- Derived constants: SLOTS = BUS_DATA_WIDTH/INS_WIDTH; INS_BYTES = INS_WIDTH/8; BUS_BYTES = BUS_DATA_WIDTH/8.
- Reset: count=0, rd/wr pointers=0, head_pc=RESET_PC, skip=RESET_PC slot index, halt=0.
  - Reset dominates redirect, push and pop.
  - ins_valid=0 and bus_ready=0 while reset=1.
- bus_ready = !reset && !redirect && !halt && (count <= DEPTH-SLOTS).
  - Computed from registered count only, with no path from ins_ready.
- Push: a beat is accepted when bus_valid && bus_ready.
  - Slots skip..SLOTS-1 are written in ascending order: slot k = bus_data[k*INS_WIDTH +: INS_WIDTH].
  - n = SLOTS-skip entries are added; skip is then cleared to 0.
- skip is loaded on redirect (and reset) with pc[$clog2(BUS_BYTES)-1 : $clog2(INS_BYTES)], the slot index of the PC within its beat. It applies to the first accepted beat only.
- Pop: occurs when ins_valid && ins_ready. The read pointer advances by 1 and head_pc increments by INS_BYTES, wrapping modulo 2^ADDR_WIDTH.
- ins_valid = (count != 0). ins and ins_pc are driven from registered storage.
  - A beat accepted in cycle N makes ins_valid=1 in cycle N+1.
- Simultaneous push and pop: count_next = count + n - 1. Storage pointers wrap modulo DEPTH.
- Full: count > DEPTH-SLOTS deasserts bus_ready. A partially filled queue never accepts a partial beat.
- Empty: ins_valid=0; ins_ready is ignored.
- Redirect (priority over push and pop, below reset):
  - Next cycle: count=0 and pointers=0.
  - head_pc = redirect_pc with the low $clog2(INS_BYTES) bits cleared.
  - skip is reloaded from the new PC; halt is cleared.
  - Any beat presented in the redirect cycle is not accepted, because bus_ready=0.
- Redirect while decode holds ins_ready=1: no pop occurs in that cycle.
- Bus protocol: bus_data is sampled only on acceptance. The producer must hold bus_valid and bus_data stable until accepted.

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- Defined:
  - When a popped instruction equals all zeros, halt is set on the next edge.
  - Once set, halt holds bus_ready=0 and forces ins_valid=0 until reset or redirect.
  - The zero instruction itself is delivered to decode, so the pop occurs.
  - Entries already queued behind it are retained but not presented.
- Undefined: halt is tied to 0 and the zero-detect logic is absent.

Decomposition:
- Package fetch_pkg holds:
  - the derived-constant functions slots(), ins_bytes() and slot_of_pc();
  - the typedef fetch_entry_t (ins, pc) for use by decode.
- Natural sub-module: fetch_queue_mem.
  - DEPTH x INS_WIDTH circular storage.
  - Multi-entry write port (up to SLOTS entries per cycle starting at wr_ptr) and single read port.
- PC tracking, skip, handshake and halt stay in the top level.

Test Plan:
- Defaults, reset, then one beat 0x2222_2222_1111_1111 with ins_ready=1 -> ins=0x1111_1111 at pc 0x0, then 0x2222_2222 at pc 0x4, then ins_valid=0; ins_count goes 2,1,0.
- ins_ready=0 and four beats offered back to back -> all four accepted, count=8, bus_ready=0. Then raise ins_ready -> eight instructions pop in order with pc 0x0..0x1C. bus_ready reasserts when count<=6.
- Redirect with redirect_pc=0x1004, then beat 0xBBBB_BBBB_AAAA_AAAA -> only 0xBBBB_BBBB is queued, ins_pc=0x1004. A beat presented in the redirect cycle is not accepted.
- Count=6, push a beat and pop in the same cycle -> count=7, FIFO order preserved; pointers wrap past entry 7 correctly.
- Assert reset mid-stream with count=5 -> next cycle count=0, ins_valid=0, ins_pc=RESET_PC.
- FETCH_HALT_ON_ZERO_EN defined, beat 0x0000_0000_0000_0013 -> 0x13 pops, then 0x0 pops, halt=1 and bus_ready=0. Redirect to 0x40 clears halt.
